// File: rtl/cp0_param_ctrl_if.sv
// rtl/cp0_param_ctrl_if.sv - M-stage <-> CP0 access, exception and interrupt signal bundle
interface cp0_param_ctrl_if #(
  parameter int NUM_HWINT = 6
);
  logic [4:0]           rd_addr;
  logic [4:0]           wr_addr;
  logic                 wr_en;
  logic [31:0]          wr_data;
  logic [31:0]          pc_m;
  logic                 bd_m;
  logic [4:0]           exc_code;
  logic [NUM_HWINT-1:0] hw_int;
  logic                 eret;
  logic                 exc_req;
  logic [31:0]          handler_pc;
  logic [31:0]          epc;
  logic [31:0]          rd_data;

  modport master (
    output rd_addr, wr_addr, wr_en, wr_data, pc_m, bd_m, exc_code, hw_int, eret,
    input  exc_req, handler_pc, epc, rd_data
  );

  modport slave (
    input  rd_addr, wr_addr, wr_en, wr_data, pc_m, bd_m, exc_code, hw_int, eret,
    output exc_req, handler_pc, epc, rd_data
  );
endinterface

// File: rtl/cp0_param_ctrl.sv
// rtl/cp0_param_ctrl.sv - CP0 SR/Cause/EPC/PRId with exception/interrupt arbitration
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_param_ctrl #(
  parameter int          NUM_HWINT  = 6,
  parameter logic [31:0] PRID_VAL   = 32'h1837_3599,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input logic             clk,
  input logic             reset,
  cp0_param_ctrl_if.slave bus
);
  logic [NUM_HWINT-1:0] im;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic [5:0]           ip;
  logic [1:0]           sw_ip;
  logic [4:0]           exccode;
  logic [31:0]          epc_q;
  logic                 ti;

  logic [5:0]  im_ext;
  logic [5:0]  ip_live;
  logic        int_req;
  logic        exc_req;
  logic        wr_ok;
  logic [31:0] pc_al;
  logic [31:0] rd_data;

  // The timer shares the highest implemented interrupt line.
  always_comb begin
    im_ext                 = '0;
    im_ext[NUM_HWINT-1:0]  = im;
    ip_live                = '0;
    ip_live[NUM_HWINT-1:0] = bus.hw_int;
    ip_live[NUM_HWINT-1]   = bus.hw_int[NUM_HWINT-1] | ti;
  end

  assign int_req = (|(ip_live & im_ext)) & ie & ~exl;
  assign exc_req = int_req | ((bus.exc_code != 5'd0) & ~exl);
  assign wr_ok   = bus.wr_en & ~exc_req & ~bus.eret;
  assign pc_al   = bus.pc_m & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b1;
      bd      <= 1'b0;
      ip      <= '0;
      sw_ip   <= '0;
      exccode <= '0;
      epc_q   <= '0;
    end else begin
      ip <= ip_live;
      if (exc_req) begin
        epc_q   <= bus.bd_m ? pc_al - 32'd4 : pc_al;
        bd      <= bus.bd_m;
        exl     <= 1'b1;
        exccode <= int_req ? 5'd0 : bus.exc_code;
      end else if (bus.eret) begin
        exl <= 1'b0;
      end else if (bus.wr_en) begin
        case (bus.wr_addr)
          5'd12: begin
            im  <= bus.wr_data[10 +: NUM_HWINT];
            exl <= bus.wr_data[1];
            ie  <= bus.wr_data[0];
          end
          5'd13:   sw_ip <= bus.wr_data[9:8];
          5'd14:   epc_q <= bus.wr_data & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if (count == compare && compare != 32'd0) ti <= 1'b1;
      if (wr_ok && bus.wr_addr == 5'd9) count <= bus.wr_data;
      if (wr_ok && bus.wr_addr == 5'd11) begin
        compare <= bus.wr_data;
        ti      <= 1'b0;
      end
    end
  end
`else
  assign ti = 1'b0;
`endif

  // Reads see registered state only; a same-cycle mtc0 is not bypassed.
  always_comb begin
    rd_data = '0;
    case (bus.rd_addr)
      5'd12: rd_data = {16'b0, im_ext, 8'b0, exl, ie};
      5'd13: rd_data = {bd, ti, 14'b0, ip, sw_ip, 1'b0, exccode, 2'b0};
      5'd14: rd_data = epc_q;
      5'd15: rd_data = PRID_VAL;
`ifdef CP0_TIMER_EN
      5'd9:  rd_data = count;
      5'd11: rd_data = compare;
`endif
      default: rd_data = '0;
    endcase
  end

  assign bus.exc_req    = exc_req;
  assign bus.handler_pc = HANDLER_PC;
  assign bus.epc        = epc_q;
  assign bus.rd_data    = rd_data;
endmodule

// File: tb/tb_cp0_param_ctrl.sv
// tb/tb_cp0_param_ctrl.sv - vector, corner-sequence and randomized checks for cp0_param_ctrl
module tb_cp0_param_ctrl;
  localparam logic [31:0] PRID = 32'h1837_3599;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  cp0_param_ctrl_if #(.NUM_HWINT(6)) bus ();

  cp0_param_ctrl #(.NUM_HWINT(6), .PRID_VAL(PRID), .HANDLER_PC(HPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } wvec_t;

  wvec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rchk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    chk(nm, bus.rd_data, exp);
  endtask

  task automatic idle;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.exc_code = '0;
    bus.eret     = 1'b0;
    bus.hw_int   = '0;
    bus.bd_m     = 1'b0;
    bus.pc_m     = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_sr, m_cause, m_epc, exp, pc, wd;
    logic [5:0]  hw;
    logic [4:0]  code, ra, wa;
    logic        bdm, er, we, intr, e;
    logic [4:0]  rd_list[8];
    logic [4:0]  wr_list[6];

    vecs[0] = '{5'd12, 32'hFFFF_FFFF, 32'h0000_FC03};
    vecs[1] = '{5'd12, 32'h0000_0401, 32'h0000_0401};
    vecs[2] = '{5'd14, 32'h1234_5677, 32'h1234_5674};
    vecs[3] = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0300};
    vecs[4] = '{5'd13, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{5'd15, 32'h0000_0000, PRID};
    vecs[6] = '{5'd3,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{5'd12, 32'h0000_0001, 32'h0000_0001};
    rd_list = '{5'd0, 5'd3, 5'd12, 5'd13, 5'd14, 5'd15, 5'd31, 5'd8};
    wr_list = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd7};

    // T1 reset state
    do_reset();
    rchk("reset_sr", 5'd12, 32'h0000_0001);
    rchk("reset_cause", 5'd13, 32'h0);
    rchk("reset_epc_reg", 5'd14, 32'h0);
    rchk("reset_prid", 5'd15, PRID);
    chk("reset_exc_req", 32'(bus.exc_req), 32'd0);
    chk("reset_epc", bus.epc, 32'h0);
    chk("handler_pc", bus.handler_pc, HPC);

    foreach (vecs[i]) begin
      mtc0(vecs[i].addr, vecs[i].wdata);
      rchk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
    end

    // T2 interrupt, mask while exl, re-fire after eret
    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001; bus.pc_m = 32'h3008; bus.bd_m = 1'b0;
    #1 chk("t2_exc_req", 32'(bus.exc_req), 32'd1);
    tick();
    chk("t2_epc", bus.epc, 32'h3008);
    rchk("t2_cause", 5'd13, 32'h0000_0400);
    rchk("t2_sr", 5'd12, 32'h0000_0403);
    chk("t2_masked", 32'(bus.exc_req), 32'd0);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    #1 chk("t2_refire", 32'(bus.exc_req), 32'd1);
    rchk("t2_sr_eret", 5'd12, 32'h0000_0401);
    bus.hw_int = '0;
    #1 chk("t2_drop", 32'(bus.exc_req), 32'd0);
    tick();

    // T3 delay-slot exception, then nested exception dropped
    bus.exc_code = 5'd4; bus.pc_m = 32'h3010; bus.bd_m = 1'b1;
    #1 chk("t3_exc_req", 32'(bus.exc_req), 32'd1);
    tick();
    bus.exc_code = 5'd10; bus.pc_m = 32'h5000; bus.bd_m = 1'b0;
    #1 chk("t3_nested_req", 32'(bus.exc_req), 32'd0);
    rchk("t3_cause", 5'd13, 32'h8000_0010);
    chk("t3_epc", bus.epc, 32'h300C);
    tick();
    bus.exc_code = '0;
    chk("t3_epc_kept", bus.epc, 32'h300C);
    rchk("t3_cause_kept", 5'd13, 32'h8000_0010);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;

    // T4 interrupt + exception + mtc0 in one cycle
    bus.hw_int = 6'b000001; bus.exc_code = 5'd12; bus.pc_m = 32'h3020; bus.bd_m = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd14; bus.wr_data = 32'hDEAD_BEE0;
    tick();
    idle();
    chk("t4_epc", bus.epc, 32'h3020);
    rchk("t4_cause", 5'd13, 32'h0000_0400);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    rchk("t4_sr_eret", 5'd12, 32'h0000_0401);
    tick();

    // mfc0 of a register being written returns the old value
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0;
    rchk("nobypass_old", 5'd12, 32'h0000_0401);
    tick();
    bus.wr_en = 1'b0;
    rchk("nobypass_new", 5'd12, 32'h0);
    mtc0(5'd12, 32'h0000_0401);

    // ip visibility latency
    bus.hw_int = 6'b101010;
    rchk("ip_before", 5'd13, 32'h0);
    tick();
    rchk("ip_after", 5'd13, 32'h0000_A800);
    bus.hw_int = '0;
    tick();

    // reset wins over a pending interrupt
    bus.hw_int = 6'b000001; bus.pc_m = 32'h4444;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.hw_int = '0;
    #1 chk("rst_pend_epc", bus.epc, 32'h0);
    rchk("rst_pend_sr", 5'd12, 32'h0000_0001);
    chk("rst_pend_req", 32'(bus.exc_req), 32'd0);

`ifdef CP0_TIMER_EN
    // T5 Count/Compare timer on the top interrupt line
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (5) tick();
    rchk("t5_count5", 5'd9, 32'd5);
    chk("t5_no_req", 32'(bus.exc_req), 32'd0);
    tick();
    chk("t5_req", 32'(bus.exc_req), 32'd1);
    bus.rd_addr = 5'd13;
    #1 chk("t5_ti", 32'(bus.rd_data[30]), 32'd1);
    tick();
    mtc0(5'd11, 32'd0);
    bus.rd_addr = 5'd13;
    #1 chk("t5_ti_clr", 32'(bus.rd_data[30]), 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rchk("t5_count_max", 5'd9, 32'hFFFF_FFFF);
    tick();
    rchk("t5_count_wrap", 5'd9, 32'h0);
`endif

    // randomized run against a word-level architectural model
    do_reset();
    m_sr = 32'h1; m_cause = 32'h0; m_epc = 32'h0;
    for (int i = 0; i < 300; i++) begin
      hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      code = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      er   = ($urandom_range(0, 5) == 0);
      we   = ($urandom_range(0, 2) == 0);
      bdm  = 1'($urandom);
      pc   = $urandom;
      wd   = $urandom;
      wa   = wr_list[$urandom_range(0, 5)];
      ra   = rd_list[$urandom_range(0, 7)];
      bus.hw_int = hw; bus.exc_code = code; bus.eret = er; bus.wr_en = we;
      bus.bd_m = bdm; bus.pc_m = pc; bus.wr_data = wd; bus.wr_addr = wa; bus.rd_addr = ra;
      #1;
      intr = (((32'(hw) << 10) & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1];
      e    = intr || (code != 0 && !m_sr[1]);
      case (ra)
        5'd12:   exp = m_sr;
        5'd13:   exp = m_cause;
        5'd14:   exp = m_epc;
        5'd15:   exp = PRID;
        default: exp = 32'h0;
      endcase
      chk("rand_exc_req", 32'(bus.exc_req), 32'(e));
      chk("rand_rd_data", bus.rd_data, exp);
      chk("rand_epc", bus.epc, m_epc);
      if (e) begin
        m_epc   = (pc & 32'hFFFF_FFFC) - (bdm ? 32'd4 : 32'd0);
        m_cause = (m_cause & 32'h7FFF_FF83) | (32'(bdm) << 31) | (32'(intr ? 5'd0 : code) << 2);
        m_sr    = m_sr | 32'h2;
      end else if (er) begin
        m_sr = m_sr & ~32'h2;
      end else if (we) begin
        if (wa == 5'd12) m_sr = wd & 32'h0000_FC03;
        if (wa == 5'd13) m_cause = (m_cause & ~32'h300) | (wd & 32'h300);
        if (wa == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
